// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t          : 32-bit data/address word
//   ramstate_t      : RAM status reported back to the memory controller
//   memctrl_state_t : memory controller arbitration states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } memctrl_state_t;

  // An access finishes on ACCESS or ERROR; ERROR is otherwise treated as a
  // normal completion.
  function automatic logic ram_done(input ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction and data cache requests onto a
// single-ported RAM. Data has priority; after STARVE_MAX consecutive data
// grants with an instruction request pending, the next grant goes to the
// instruction side.
//
// Ports:
//   CLK, nRST                  clock, synchronous active-low reset
//   iREN, iaddr                instruction read request
//   dREN, dWEN, daddr, dstore  data read/write request
//   iwait, dwait               0 = access completes this cycle
//   iload, dload               read data, valid only in the completion cycle
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload,
//   ramstate                   RAM side
//   mem_err                    sticky, set on any ERROR completion
//   icount, dcount, stallcnt   performance counters (only with
//                              MEM_CTRL_PERF_EN defined)
//
// Build option: define MEM_CTRL_PERF_EN to add the performance counters.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no owner, no strobes; picks the next grant
// DACC  | data side owns the RAM
// IACC  | instruction side owns the RAM
module mem_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       iREN,
  input  word_t      iaddr,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       iwait,
  output logic       dwait,
  output word_t      iload,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  logic [1:0] ramstate,
`ifdef MEM_CTRL_PERF_EN
  output word_t      icount,
  output word_t      dcount,
  output word_t      stallcnt,
`endif
  output logic       mem_err
);

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  memctrl_state_t state, state_nx;
  logic [3:0]     starve, starve_nx;
  logic           err_nx;
  logic           dreq;
  logic           done;
  logic           i_done, d_done;
  ramstate_t      rs;

  assign rs   = ramstate_t'(ramstate);
  assign dreq = dREN | dWEN;
  assign done = ram_done(rs);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      starve  <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nx;
      starve  <= starve_nx;
      mem_err <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    err_nx    = mem_err;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;

    case (state)
      IDLE: begin
        if (dreq && !(iREN && starve == SMAX)) state_nx = DACC;
        else if (iREN)                          state_nx = IACC;
      end

      DACC: begin
        if (!dreq) begin
          // Abort: strobes already drop with the request; starve untouched.
          state_nx = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (done) begin
            dwait    = 1'b0;
            dload    = ramload;
            d_done   = 1'b1;
            state_nx = IDLE;
            if (!iREN)              starve_nx = '0;
            else if (starve < SMAX) starve_nx = starve + 4'd1;
            if (rs == ERROR) err_nx = 1'b1;
          end
        end
      end

      IACC: begin
        if (!iREN) begin
          state_nx = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (done) begin
            iwait     = 1'b0;
            iload     = ramload;
            i_done    = 1'b1;
            state_nx  = IDLE;
            starve_nx = '0;
            if (rs == ERROR) err_nx = 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

`ifdef MEM_CTRL_PERF_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      icount   <= '0;
      dcount   <= '0;
      stallcnt <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
      if ((iwait && iREN) || (dwait && dreq)) stallcnt <= stallcnt + 32'd1;
    end
  end
`else
  logic unused_done;
  assign unused_done = i_done ^ d_done;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios followed by a random
// phase, every cycle compared against a transaction-level reference model.
module tb_mem_ctrl;
  import cpu_types_pkg::*;

  localparam int SM = 4;
  localparam int OWN_NONE = 0, OWN_D = 1, OWN_I = 2;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       iREN, dREN, dWEN;
  word_t      iaddr, daddr, dstore, ramload;
  logic [1:0] ramstate;
  logic       iwait, dwait, ramREN, ramWEN, mem_err;
  word_t      iload, dload, ramaddr, ramstore;
`ifdef MEM_CTRL_PERF_EN
  word_t      icount, dcount, stallcnt;
`endif

  mem_ctrl #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
`ifdef MEM_CTRL_PERF_EN
    .icount(icount), .dcount(dcount), .stallcnt(stallcnt),
`endif
    .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // reference model: who owns the RAM, how many data grants in a row
  int m_own = OWN_NONE;
  int m_starve = 0;
  bit m_err = 1'b0;
  longint m_icnt = 0, m_dcnt = 0, m_stall = 0;

  // DUT observations from the most recent step
  int    ipulses = 0, dpulses = 0;
  logic  last_iwait, last_dwait, last_ren, last_wen;
  word_t last_addr, last_store, last_iload, last_dload;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set; compare at negedge, advance model
  // at posedge, return 1 time unit after the edge.
  task automatic step();
    logic  e_iwait, e_dwait, e_ren, e_wen, dreq, fin;
    word_t e_addr, e_store, e_iload, e_dload;
    int    n_own, n_starve;
    bit    n_err;
    @(negedge CLK);
    dreq = dREN | dWEN;
    fin  = (ramstate == 2'd2) || (ramstate == 2'd3);
    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
    n_own = m_own; n_starve = m_starve; n_err = m_err;
    if (m_own == OWN_NONE) begin
      if (dreq && !(iREN && m_starve == SM)) n_own = OWN_D;
      else if (iREN)                         n_own = OWN_I;
    end else if (m_own == OWN_D) begin
      if (!dreq) n_own = OWN_NONE;
      else begin
        e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore;
        if (fin) begin
          e_dwait = 1'b0; e_dload = ramload; n_own = OWN_NONE;
          n_starve = iREN ? ((m_starve + 1 > SM) ? SM : m_starve + 1) : 0;
          if (ramstate == 2'd3) n_err = 1'b1;
          m_dcnt++;
        end
      end
    end else begin
      if (!iREN) n_own = OWN_NONE;
      else begin
        e_ren = 1'b1; e_addr = iaddr;
        if (fin) begin
          e_iwait = 1'b0; e_iload = ramload; n_own = OWN_NONE; n_starve = 0;
          if (ramstate == 2'd3) n_err = 1'b1;
          m_icnt++;
        end
      end
    end
    if ((e_iwait && iREN) || (e_dwait && dreq)) m_stall++;

    chk("iwait", word_t'(iwait), word_t'(e_iwait));
    chk("dwait", word_t'(dwait), word_t'(e_dwait));
    chk("iload", iload, e_iload);
    chk("dload", dload, e_dload);
    chk("ramREN", word_t'(ramREN), word_t'(e_ren));
    chk("ramWEN", word_t'(ramWEN), word_t'(e_wen));
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("mem_err", word_t'(mem_err), word_t'(m_err));
`ifdef MEM_CTRL_PERF_EN
    chk("icount", icount, word_t'(m_icnt - (fin && m_own == OWN_I && iREN ? 1 : 0)));
    chk("dcount", dcount, word_t'(m_dcnt - (fin && m_own == OWN_D && dreq ? 1 : 0)));
    chk("stallcnt", stallcnt,
        word_t'(m_stall - (((e_iwait && iREN) || (e_dwait && dreq)) ? 1 : 0)));
`endif
    last_iwait = iwait; last_dwait = dwait; last_ren = ramREN; last_wen = ramWEN;
    last_addr = ramaddr; last_store = ramstore; last_iload = iload; last_dload = dload;
    if (iwait === 1'b0) ipulses++;
    if (dwait === 1'b0) dpulses++;

    @(posedge CLK);
    if (!nRST) begin
      m_own = OWN_NONE; m_starve = 0; m_err = 1'b0;
      m_icnt = 0; m_dcnt = 0; m_stall = 0;
    end else begin
      m_own = n_own; m_starve = n_starve; m_err = n_err;
    end
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 0;
    step();
    nRST = 1;
    ipulses = 0; dpulses = 0;
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    m_own = OWN_NONE;
    step();
    nRST = 1;
    step();
    chk("reset_iwait", word_t'(iwait), 32'd1);
    chk("reset_mem_err", word_t'(mem_err), 32'd0);

    // data read with two BUSY cycles before ACCESS
    do_reset();
    dREN = 1; daddr = 32'h40; ramload = 32'hDEADBEEF; ramstate = 2'd1;
    step();
    step();
    chk("t1_ramREN", word_t'(last_ren), 32'd1);
    chk("t1_ramaddr", last_addr, 32'h40);
    step();
    ramstate = 2'd2;
    step();
    chk("t1_dwait", word_t'(last_dwait), 32'd0);
    chk("t1_dload", last_dload, 32'hDEADBEEF);
    dREN = 0; ramstate = 2'd0;
    step();
    chk("t1_idle_ren", word_t'(last_ren), 32'd0);
    chk("t1_dpulses", word_t'(dpulses), 32'd1);

    // simultaneous I and D: D first
    do_reset();
    iREN = 1; iaddr = 32'h200; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    ramstate = 2'd2; ramload = 32'h0BADF00D;
    step();
    step();
    chk("t2_ramWEN", word_t'(last_wen), 32'd1);
    chk("t2_ramstore", last_store, 32'h12345678);
    chk("t2_iwait_hold", word_t'(last_iwait), 32'd1);
    dWEN = 0;
    step();
    step();
    chk("t2_iwait_done", word_t'(last_iwait), 32'd0);
    chk("t2_iload", last_iload, 32'h0BADF00D);
    chk("t2_ipulses", word_t'(ipulses), 32'd1);
    iREN = 0;
    step();

    // starvation bound: D,D,D,D,I repeating
    do_reset();
    iREN = 1; dREN = 1; ramstate = 2'd2;
    for (int k = 0; k < 20; k++) step();
    chk("t3_ipulses", word_t'(ipulses), 32'd2);
    chk("t3_dpulses", word_t'(dpulses), 32'd8);

    // ERROR completion, sticky mem_err
    do_reset();
    iREN = 1; iaddr = 32'h100; ramstate = 2'd0;
    step();
    ramstate = 2'd3;
    step();
    chk("t4_iwait", word_t'(last_iwait), 32'd0);
    iREN = 0; ramstate = 2'd0;
    step();
    chk("t4_err_set", word_t'(mem_err), 32'd1);
    dREN = 1; ramstate = 2'd2;
    step();
    step();
    dREN = 0;
    step();
    chk("t4_err_sticky", word_t'(mem_err), 32'd1);
    chk("t4_ipulses", word_t'(ipulses), 32'd1);

    // abort mid-DACC
    do_reset();
    dREN = 1; daddr = 32'h44; ramstate = 2'd1;
    step();
    step();
    dREN = 0;
    step();
    chk("t5_abort_ren", word_t'(last_ren), 32'd0);
    chk("t5_abort_dwait", word_t'(last_dwait), 32'd1);
    step();
    chk("t5_dpulses", word_t'(dpulses), 32'd0);

    // reset mid-IACC (mem_err set beforehand)
    do_reset();
    iREN = 1; iaddr = 32'h300; ramstate = 2'd3;
    step();
    step();
    ramstate = 2'd1;
    step();
    step();
    nRST = 0;
    step();
    chk("t6_iwait", word_t'(iwait), 32'd1);
    chk("t6_ramREN", word_t'(ramREN), 32'd0);
    chk("t6_mem_err", word_t'(mem_err), 32'd0);
    nRST = 1; iREN = 0;
    step();

`ifdef MEM_CTRL_PERF_EN
    do_reset();
    dREN = 1; ramstate = 2'd2;
    for (int k = 0; k < 6; k++) step();
    dREN = 0; iREN = 1;
    for (int k = 0; k < 4; k++) step();
    iREN = 0;
    step();
    chk("perf_dcount", dcount, 32'd3);
    chk("perf_icount", icount, 32'd2);
    nRST = 0;
    step();
    nRST = 1;
    chk("perf_rst_d", dcount, 32'd0);
    chk("perf_rst_i", icount, 32'd0);
    chk("perf_rst_s", stallcnt, 32'd0);
`endif

    // random traffic
    do_reset();
    for (int k = 0; k < 500; k++) begin
      int sel;
      nRST = ($urandom_range(0, 63) != 0);
      iREN = ($urandom_range(0, 3) != 0);
      sel  = $urandom_range(0, 3);
      dREN = (sel == 1);
      dWEN = (sel == 2);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
